round_16b_8b: RTL and testbench

- Per-lane requantizer that converts one signed 16-bit accumulator/bias value to a signed 8-bit output.
- Applies an optional arithmetic right shift with a selectable rounding mode, then saturates to int8.
- 32 instances sit in the NPU output-rounding stage; all lanes share one shift amount and one mode.
- The shift amount comes from a register that holds (input Q + weight Q − output Q).

---
 rtl/round_16b_8b_if.sv | 30 +++
 rtl/round_16b_8b.sv | 61 ++++++
 tb/tb_round_16b_8b.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/round_16b_8b_if.sv
`default_nettype none
// ============================================================================
// Module : round_16b_8b_if
// Brief  : Sample/control bundle for one requantizer lane (16b in, 8b out).
// Rev    : 1.0  initial release
// ============================================================================
interface round_16b_8b_if;
    logic [4:0]  shift_num;
    logic        i_shift_en;
    logic [1:0]  i_round_mode;
    logic [15:0] dat_i;
    logic [7:0]  dat_o;

    modport master (
        output shift_num,
        output i_shift_en,
        output i_round_mode,
        output dat_i,
        input  dat_o
    );

    modport slave (
        input  shift_num,
        input  i_shift_en,
        input  i_round_mode,
        input  dat_i,
        output dat_o
    );
endinterface
`default_nettype wire

// File: rtl/round_16b_8b.sv
`default_nettype none
// ============================================================================
// Module : round_16b_8b
// Brief  : Signed 16b -> 8b requantizer: shift, round (trunc/half-up/even), saturate.
// Rev    : 1.0  initial release
// ============================================================================
module round_16b_8b (
    input  wire logic       i_clk,
    input  wire logic       i_rst_n,
    round_16b_8b_if.slave   bus
);
    localparam logic [1:0] C_MODE_HALF_UP   = 2'd1;
    localparam logic [1:0] C_MODE_HALF_EVEN = 2'd2;

    logic signed [47:0] w_x;
    logic signed [47:0] w_q;
    logic        [47:0] w_rem;
    logic        [47:0] w_half;
    logic        [4:0]  w_s;
    logic               w_inc;
    logic signed [47:0] w_y;
    logic        [7:0]  w_sat;
    logic        [7:0]  r_dat;

    always_comb begin
        w_x    = {{32{bus.dat_i[15]}}, bus.dat_i};
        w_s    = bus.i_shift_en ? bus.shift_num : 5'd0;
        w_q    = w_x >>> w_s;
        // Remainder is always in [0, 2^s) because q is a floor quotient.
        w_rem  = w_x - (w_q <<< w_s);
        w_half = (w_s == 5'd0) ? 48'd0 : (48'd1 << (w_s - 5'd1));

        w_inc = 1'b0;
        if (w_s != 5'd0) begin
            case (bus.i_round_mode)
                C_MODE_HALF_UP:   w_inc = (w_rem >= w_half);
                C_MODE_HALF_EVEN: w_inc = (w_rem > w_half) || ((w_rem == w_half) && w_q[0]);
                default:          w_inc = 1'b0;
            endcase
        end

        w_y = w_q + {47'd0, w_inc};

        if (w_y > 48'sd127)
            w_sat = 8'h7F;
        else if (w_y < -48'sd128)
            w_sat = 8'h80;
        else
            w_sat = w_y[7:0];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_dat <= 8'h00;
        else
            r_dat <= w_sat;
    end

    assign bus.dat_o = r_dat;
endmodule
`default_nettype wire

// File: tb/tb_round_16b_8b.sv
`default_nettype none
// ============================================================================
// Module : tb_round_16b_8b
// Brief  : Directed vector table, reset sequence and random stream vs. arithmetic model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_round_16b_8b;
    logic i_clk;
    logic i_rst_n;
    int   n_checks;
    int   n_fail;

    round_16b_8b_if bus ();

    round_16b_8b dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [15:0] dat;
        logic [4:0]  sh;
        logic        en;
        logic [1:0]  md;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs [19];

    // Floor division and explicit remainder comparison against 2^(s-1).
    function automatic logic [7:0] ref_model(input logic [15:0] d, input logic [4:0] sh,
                                             input logic en, input logic [1:0] md);
        longint x;
        longint p;
        longint q;
        longint r;
        longint y;
        int     s;
        logic [63:0] yb;
        x = longint'($signed(d));
        s = en ? int'(sh) : 0;
        p = longint'(1) << s;
        if (x >= 0) q = x / p;
        else        q = -((-x + p - 1) / p);
        r = x - q * p;
        y = q;
        if (s > 0) begin
            if (md == 2'd1 && 2 * r >= p)
                y = q + 1;
            else if (md == 2'd2 && (2 * r > p || (2 * r == p && (q % 2) != 0)))
                y = q + 1;
        end
        if (y > 127)  return 8'h7F;
        if (y < -128) return 8'h80;
        yb = 64'(y);
        return yb[7:0];
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: dat_o=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] d, input logic [4:0] sh,
                         input logic en, input logic [1:0] md);
        bus.dat_i        = d;
        bus.shift_num    = sh;
        bus.i_shift_en   = en;
        bus.i_round_mode = md;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        vecs[0]  = '{16'd344,  5'd4,  1'b1, 2'd0, 8'd21};
        vecs[1]  = '{16'd344,  5'd4,  1'b1, 2'd1, 8'd22};
        vecs[2]  = '{16'd344,  5'd4,  1'b1, 2'd2, 8'd22};
        vecs[3]  = '{16'd344,  5'd4,  1'b1, 2'd3, 8'd21};
        vecs[4]  = '{16'd328,  5'd4,  1'b1, 2'd2, 8'd20};
        vecs[5]  = '{16'd328,  5'd4,  1'b1, 2'd1, 8'd21};
        vecs[6]  = '{16'hFEA8, 5'd4,  1'b1, 2'd0, 8'hEA};
        vecs[7]  = '{16'hFEA8, 5'd4,  1'b1, 2'd1, 8'hEB};
        vecs[8]  = '{16'hFEA8, 5'd4,  1'b1, 2'd2, 8'hEA};
        vecs[9]  = '{16'h7FFF, 5'd4,  1'b1, 2'd1, 8'h7F};
        vecs[10] = '{16'h8000, 5'd4,  1'b1, 2'd0, 8'h80};
        vecs[11] = '{16'd300,  5'd4,  1'b0, 2'd1, 8'h7F};
        vecs[12] = '{16'd100,  5'd4,  1'b0, 2'd1, 8'h64};
        vecs[13] = '{16'hFFFB, 5'd4,  1'b0, 2'd1, 8'hFB};
        vecs[14] = '{16'h8000, 5'd31, 1'b1, 2'd0, 8'hFF};
        vecs[15] = '{16'h8000, 5'd31, 1'b1, 2'd1, 8'h00};
        vecs[16] = '{16'd7,    5'd0,  1'b1, 2'd1, 8'h07};
        vecs[17] = '{16'd255,  5'd1,  1'b1, 2'd1, 8'h7F};
        vecs[18] = '{16'hFFFF, 5'd20, 1'b1, 2'd1, 8'h00};

        // Reset held from time zero: output must already be zero before any edge.
        i_rst_n = 1'b0;
        drive(16'h0158, 5'd4, 1'b1, 2'd1);
        #2;
        check("reset_initial", bus.dat_o, 8'h00);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge i_clk);
            drive(vecs[i].dat, vecs[i].sh, vecs[i].en, vecs[i].md);
            @(posedge i_clk);
            #1;
            check($sformatf("vec%0d", i), bus.dat_o, vecs[i].exp);
        end

        // Mid-stream asynchronous reset with a nonzero pending result.
        @(negedge i_clk);
        drive(16'h0158, 5'd4, 1'b1, 2'd1);
        @(posedge i_clk);
        #1;
        check("pre_reset", bus.dat_o, 8'd22);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("reset_async", bus.dat_o, 8'h00);
        repeat (2) @(posedge i_clk);
        #1;
        check("reset_hold", bus.dat_o, 8'h00);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        drive(16'd344, 5'd4, 1'b1, 2'd0);
        #1;
        check("release_no_edge", bus.dat_o, 8'h00);
        @(posedge i_clk);
        #1;
        check("first_after_release", bus.dat_o, 8'd21);

        // Back-to-back random stream, new sample every cycle.
        for (int k = 0; k < 32; k++) begin
            logic [15:0] d;
            logic [4:0]  sh;
            logic        en;
            logic [1:0]  md;
            logic [7:0]  exp;
            @(negedge i_clk);
            d  = 16'($urandom);
            sh = 5'($urandom_range(0, 31));
            en = 1'($urandom);
            md = 2'($urandom);
            drive(d, sh, en, md);
            exp = ref_model(d, sh, en, md);
            @(posedge i_clk);
            #1;
            check($sformatf("rand%0d d=%h s=%0d en=%0b m=%0d", k, d, sh, en, md), bus.dat_o, exp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
